// File: rtl/vga_pkg.sv
// Shared VGA pipeline types and default sprite constants.
package vga_pkg;

    typedef struct packed {
        logic [10:0] vcount;
        logic [10:0] hcount;
        logic        vsync;
        logic        hsync;
        logic        vblnk;
        logic        hblnk;
    } vga_tim_t;

    localparam int          SPRITE_W_DEF   = 64;
    localparam int          SPRITE_H_DEF   = 64;
    localparam logic [11:0] TRANSP_RGB_DEF = 12'h0F0;

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle: timing plus colour.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/vga_delay.sv
// N-stage delay line for VGA timing and colour, synchronous reset.
module vga_delay
    import vga_pkg::*;
#(
    parameter int N = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  vga_tim_t    tim_in,
    input  logic [11:0] rgb_in,
    output vga_tim_t    tim_out,
    output logic [11:0] rgb_out
);

    vga_tim_t    tim_q [N];
    logic [11:0] rgb_q [N];

    // Shift timing and colour one stage per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                tim_q[i] <= '0;
                rgb_q[i] <= '0;
            end
        end else begin
            tim_q[0] <= tim_in;
            rgb_q[0] <= rgb_in;
            for (int i = 1; i < N; i++) begin
                tim_q[i] <= tim_q[i-1];
                rgb_q[i] <= rgb_q[i-1];
            end
        end
    end

    assign tim_out = tim_q[N-1];
    assign rgb_out = rgb_q[N-1];

endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage: hit test + ROM fetch, 3-clock delay-matched output.
module draw_sprite
    import vga_pkg::*;
#(
    parameter int          SPRITE_W   = SPRITE_W_DEF,
    parameter int          SPRITE_H   = SPRITE_H_DEF,
    parameter logic [11:0] TRANSP_RGB = TRANSP_RGB_DEF,
    localparam int         ADDR_W     = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    vga_if.in                 in,
    vga_if.out                out,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data
);

    logic [10:0]       x_lat, y_lat;
    logic [11:0]       hc, vc, x_end, y_end, dx, dy;
    logic              hit;
    logic [ADDR_W-1:0] addr_next;
    logic [2:1]        hit_pipe;
    vga_tim_t          tim_in, tim_s2;
    logic [11:0]       rgb_s2;

    // Hit test and address in 12 bits so a sprite near 2047 clips instead of wrapping.
    always_comb begin
        tim_in    = '{vcount: in.vcount, hcount: in.hcount, vsync: in.vsync,
                      hsync: in.hsync, vblnk: in.vblnk, hblnk: in.hblnk};
        hc        = {1'b0, in.hcount};
        vc        = {1'b0, in.vcount};
        x_end     = {1'b0, x_lat} + 12'(SPRITE_W);
        y_end     = {1'b0, y_lat} + 12'(SPRITE_H);
        dx        = hc - {1'b0, x_lat};
        dy        = vc - {1'b0, y_lat};
        hit       = !in.hblnk && !in.vblnk &&
                    hc >= {1'b0, x_lat} && hc < x_end &&
                    vc >= {1'b0, y_lat} && vc < y_end;
        addr_next = ADDR_W'(32'(dy) * SPRITE_W + 32'(dx));
    end

    // Stage 1: position latch at frame origin, ROM address, hit flag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_lat    <= '0;
            y_lat    <= '0;
            rom_addr <= '0;
            hit_pipe <= '0;
        end else begin
            if (in.hcount == 11'd0 && in.vcount == 11'd0) begin
                x_lat <= xpos;
                y_lat <= ypos;
            end
            if (hit)
                rom_addr <= addr_next;
            hit_pipe <= {hit_pipe[1], hit};
        end
    end

    // Stages 1..2 for timing and background colour; S2 lines up with rom_data.
    vga_delay #(.N(2)) u_delay (
        .clk     (clk),
        .rst     (rst),
        .tim_in  (tim_in),
        .rgb_in  (in.rgb),
        .tim_out (tim_s2),
        .rgb_out (rgb_s2)
    );

    // Stage 3: register output; blanking beats sprite, transparent key shows background.
    always_ff @(posedge clk) begin
        if (rst) begin
            out.vcount <= '0;
            out.hcount <= '0;
            out.vsync  <= 1'b0;
            out.hsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.vcount <= tim_s2.vcount;
            out.hcount <= tim_s2.hcount;
            out.vsync  <= tim_s2.vsync;
            out.hsync  <= tim_s2.hsync;
            out.vblnk  <= tim_s2.vblnk;
            out.hblnk  <= tim_s2.hblnk;
            if (tim_s2.hblnk || tim_s2.vblnk)
                out.rgb <= 12'h000;
            else if (hit_pipe[2] && rom_data != TRANSP_RGB)
                out.rgb <= rom_data;
            else
                out.rgb <= rgb_s2;
        end
    end

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite with a synchronous ROM model.
module tb_draw_sprite;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] xpos, ypos;
    logic [11:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] rom [4096];
    int          n_cmp = 0;
    int          n_bad = 0;

    vga_if vin();
    vga_if vout();

    draw_sprite dut (
        .clk      (clk),
        .rst      (rst),
        .xpos     (xpos),
        .ypos     (ypos),
        .in       (vin),
        .out      (vout),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    // Registered ROM: data valid one clock after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input logic hb, input logic vb,
                         input logic [11:0] rgb, input logic hs = 1'b0, input logic vs = 1'b0);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.rgb    = rgb;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present pixel at frame origin so xpos/ypos get latched.
    task automatic latch(input int x, input int y);
        xpos = 11'(x);
        ypos = 11'(y);
        drive(0, 0, 1'b1, 1'b1, 12'h000);
        step;
    endtask

    // One pixel through the pipe; idle blank filler behind it.
    task automatic shot(input string tag, input int h, input int v, input logic hb,
                        input logic vb, input logic [11:0] rgb, input logic [11:0] exp_rgb,
                        input int exp_addr);
        drive(h, v, hb, vb, rgb);
        step;
        if (exp_addr >= 0) chk({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
        drive(1000, 700, 1'b1, 1'b1, 12'h000);
        step;
        step;
        chk({tag, ".rgb"}, 32'(vout.rgb), 32'(exp_rgb));
        chk({tag, ".hc"},  32'(vout.hcount), 32'(h));
        chk({tag, ".vc"},  32'(vout.vcount), 32'(v));
        chk({tag, ".hb"},  32'(vout.hblnk), 32'(hb));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 12'(i) ^ 12'hA00;
        rom[0]    = 12'hDEF;
        rom[27]   = 12'hC1C;
        rom[64]   = 12'hD2D;
        rom[127]  = 12'hE3E;
        rom[131]  = 12'hABC;
        rom[191]  = 12'h5E5;
        rom[4035] = 12'h7A7;

        // Reset held with a live mid-frame pixel on the input.
        rst  = 1'b1;
        xpos = 11'd0;
        ypos = 11'd0;
        drive(500, 300, 1'b0, 1'b0, 12'hFFF, 1'b1, 1'b1);
        repeat (5) step;
        chk("rst.hc",   32'(vout.hcount), 0);
        chk("rst.vc",   32'(vout.vcount), 0);
        chk("rst.rgb",  32'(vout.rgb), 0);
        chk("rst.hs",   32'(vout.hsync), 0);
        chk("rst.vs",   32'(vout.vsync), 0);
        chk("rst.addr", 32'(rom_addr), 0);

        // Release: output equals input from 3 clocks earlier.
        rst = 1'b0;
        drive(10, 300, 1'b0, 1'b0, 12'h222, 1'b1, 1'b0);
        step;
        drive(11, 300, 1'b0, 1'b0, 12'h222);
        step;
        drive(12, 300, 1'b0, 1'b0, 12'h222);
        step;
        chk("rel.hc", 32'(vout.hcount), 10);
        chk("rel.hs", 32'(vout.hsync), 1);
        step;
        chk("rel.hc2", 32'(vout.hcount), 11);

        // Opaque, transparent, blanked, and window edges.
        latch(100, 50);
        shot("opaque", 103, 52, 1'b0, 1'b0, 12'h111, 12'hABC, 131);
        rom[131] = 12'h0F0;
        shot("transp", 103, 52, 1'b0, 1'b0, 12'h111, 12'h111, 131);
        rom[131] = 12'hABC;
        shot("hblank", 103, 52, 1'b1, 1'b0, 12'hFFF, 12'h000, -1);
        shot("vblank", 103, 52, 1'b0, 1'b1, 12'hFFF, 12'h000, -1);
        shot("left",   99, 52, 1'b0, 1'b0, 12'h222, 12'h222, -1);
        shot("right",  163, 52, 1'b0, 1'b0, 12'h222, 12'h5E5, 191);
        shot("rightx", 164, 52, 1'b0, 1'b0, 12'h222, 12'h222, -1);
        shot("above",  103, 49, 1'b0, 1'b0, 12'h222, 12'h222, -1);
        shot("bottom", 103, 113, 1'b0, 1'b0, 12'h222, 12'h7A7, 4035);
        shot("below",  103, 114, 1'b0, 1'b0, 12'h222, 12'h222, -1);

        // Position change mid-frame is ignored until the next frame origin.
        xpos = 11'd300;
        shot("hold.old", 103, 52, 1'b0, 1'b0, 12'h333, 12'hABC, 131);
        shot("hold.new", 303, 52, 1'b0, 1'b0, 12'h333, 12'h333, -1);
        latch(300, 50);
        shot("move.new", 303, 52, 1'b0, 1'b0, 12'h333, 12'hABC, 131);
        shot("move.old", 103, 52, 1'b0, 1'b0, 12'h333, 12'h333, -1);

        // Latch cycle that is also a hit uses the old position.
        latch(0, 0);
        xpos = 11'd500;
        shot("coinc", 0, 0, 1'b0, 1'b0, 12'h333, 12'hDEF, 0);
        shot("coinc.next", 0, 1, 1'b0, 1'b0, 12'h444, 12'h444, -1);

        // Clipping at the right edge of the count range, no wrap to hcount 0.
        latch(2020, 0);
        shot("clip.end",   2047, 0, 1'b0, 1'b0, 12'h555, 12'hC1C, 27);
        shot("clip.start", 2020, 1, 1'b0, 1'b0, 12'h555, 12'hD2D, 64);
        shot("clip.h0",    0, 1, 1'b0, 1'b0, 12'h555, 12'h555, -1);
        shot("clip.h35",   35, 1, 1'b0, 1'b0, 12'h555, 12'h555, -1);

        // Mid-frame reset clears the latched position.
        latch(100, 50);
        rst = 1'b1;
        drive(103, 52, 1'b0, 1'b0, 12'hFFF);
        repeat (5) step;
        chk("rst2.rgb",  32'(vout.rgb), 0);
        chk("rst2.addr", 32'(rom_addr), 0);
        rst = 1'b0;
        shot("rst2.pos", 103, 52, 1'b0, 1'b0, 12'h666, 12'h666, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
